link_uart_rx: RTL and testbench



---
 rtl/link_uart_rx.sv | 138 +++++++++++++
 tb/tb_link_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/link_uart_rx.sv
// Serial link receiver: 8E1 frames over one idle-high wire, decoded into
// single-cycle command pulses and latched game id / remote score.
module link_uart_rx #(
  parameter int CLKS_PER_BIT = 4167,
  parameter int CNT_WIDTH    = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       invite_pulse,
  output logic       cancel_pulse,
  output logic       start_pulse,
  output logic [2:0] game_sel,
  output logic [4:0] remote_score
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(CLKS_PER_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] HALF = CNT_WIDTH'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] OP_INVITE = 3'b001;
  localparam logic [2:0] OP_CANCEL = 3'b010;
  localparam logic [2:0] OP_START  = 3'b011;
  localparam logic [2:0] OP_POINT  = 3'b100;

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 rx_m, rx_s;
  logic [CNT_WIDTH-1:0] cnt;
  logic [7:0]           shift;
  logic [2:0]           idx;
  logic                 par;
  logic                 cnt_clr, data_tick, good, bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b0;
      rx_s <= 1'b0;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    data_tick = 1'b0;
    good      = 1'b0;
    bad       = 1'b0;
    unique case (state)
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      IDLE: if (!rx_s) begin
        state_nxt = START;
        cnt_clr   = 1'b1;
      end
      START: if (cnt == HALF) begin
        cnt_clr   = 1'b1;
        state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == FULL) begin
        cnt_clr   = 1'b1;
        data_tick = 1'b1;
        if (idx == 3'd7) state_nxt = PARITY;
      end
      PARITY: if (cnt == FULL) begin
        cnt_clr   = 1'b1;
        state_nxt = STOP;
      end
      // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
      STOP: if (cnt == FULL) begin
        cnt_clr = 1'b1;
        if (!rx_s) begin
          bad       = 1'b1;
          state_nxt = WAIT_IDLE;
        end else if (^{shift, par}) begin
          bad       = 1'b1;
          state_nxt = IDLE;
        end else begin
          good      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      shift <= '0;
      idx   <= '0;
      par   <= 1'b0;
    end else begin
      if (cnt_clr || state == IDLE || state == WAIT_IDLE) cnt <= '0;
      else                                                cnt <= cnt + CNT_WIDTH'(1);
      if (state == START) idx <= '0;
      if (data_tick) begin
        shift[idx] <= rx_s;
        idx        <= idx + 3'd1;
      end
      if (state == PARITY && cnt == FULL) par <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      invite_pulse <= 1'b0;
      cancel_pulse <= 1'b0;
      start_pulse  <= 1'b0;
      game_sel     <= '0;
      remote_score <= '0;
    end else begin
      rx_valid     <= good;
      frame_err    <= bad;
      invite_pulse <= good && shift[7:5] == OP_INVITE;
      cancel_pulse <= good && shift[7:5] == OP_CANCEL;
      start_pulse  <= good && shift[7:5] == OP_START;
      if (good) begin
        rx_data <= shift;
        if (shift[7:5] == OP_INVITE) game_sel     <= shift[2:0];
        if (shift[7:5] == OP_POINT)  remote_score <= shift[4:0];
      end
    end
  end

endmodule

// File: tb/tb_link_uart_rx.sv
// Scoreboard bench for link_uart_rx: driver pushes expected events from a
// frame-level model, a negedge monitor pops and compares each output event.
module tb_link_uart_rx;
  localparam int C   = 16;
  localparam int CW  = 5;
  localparam int LAT = 3 + C / 2 + 10 * C;

  logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, invite_pulse, cancel_pulse, start_pulse;
  logic [2:0] game_sel;
  logic [4:0] remote_score;

  link_uart_rx #(.CLKS_PER_BIT(C), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .invite_pulse(invite_pulse), .cancel_pulse(cancel_pulse),
    .start_pulse(start_pulse), .game_sel(game_sel), .remote_score(remote_score));

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
    bit         inv, can, st;
    logic [2:0] gsel;
    logic [4:0] score;
    int         t;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         checks = 0, passed = 0, cyc = 0;
  logic [7:0] m_data = '0;
  logic [2:0] m_gsel = '0;
  logic [4:0] m_score = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Frame-level reference: a good frame updates the latches by opcode; a bad one changes nothing.
  task automatic expect_frame(input logic [7:0] b, input bit bad, input int t0);
    exp_t e;
    if (!bad) begin
      m_data = b;
      if (b[7:5] == 3'd1) m_gsel = b[2:0];
      if (b[7:5] == 3'd4) m_score = b[4:0];
    end
    e.err = bad; e.data = m_data; e.gsel = m_gsel; e.score = m_score;
    e.inv = !bad && b[7:5] == 3'd1;
    e.can = !bad && b[7:5] == 3'd2;
    e.st  = !bad && b[7:5] == 3'd3;
    e.t   = t0 + LAT;
    q.push_back(e);
  endtask

  // All driver tasks start and end at posedge+1.
  task automatic drive_bit(input logic v);
    rx = v;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par);
    expect_frame(b, flip_par, cyc);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((^b) ^ flip_par);
    drive_bit(1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_flags"}, {rx_valid, frame_err, invite_pulse, cancel_pulse, start_pulse}, 0);
    chk({tag, "_game_sel"}, game_sel, 0);
    chk({tag, "_remote_score"}, remote_score, 0);
  endtask

  always @(negedge clk) begin
    if (!rst && (rx_valid || frame_err || invite_pulse || cancel_pulse || start_pulse)) begin
      if (rx_valid && frame_err) chk("valid_err_exclusive", 1, 0);
      if (q.size() == 0) begin
        chk("unexpected_output", {rx_valid, frame_err, invite_pulse, cancel_pulse, start_pulse}, 0);
      end else begin
        mon_e = q.pop_front();
        chk("time", cyc, mon_e.t);
        chk("rx_valid", rx_valid, !mon_e.err);
        chk("frame_err", frame_err, mon_e.err);
        chk("pulses", {invite_pulse, cancel_pulse, start_pulse}, {mon_e.inv, mon_e.can, mon_e.st});
        chk("rx_data", rx_data, mon_e.data);
        chk("game_sel", game_sel, mon_e.gsel);
        chk("remote_score", remote_score, mon_e.score);
      end
    end
  end

  initial begin
    int waited;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    idle(2 * C);

    // 1: INVITE arg 5
    send_frame(8'h25, 1'b0);
    idle(C);
    // 2: POINT 12 then CANCEL back-to-back
    send_frame(8'h8C, 1'b0);
    send_frame(8'h40, 1'b0);
    idle(C);
    // 3: START with bad parity
    send_frame(8'h60, 1'b1);
    idle(C);
    // 4: short glitch is a false start, then a real frame
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(3 * C);
    send_frame(8'h25, 1'b0);
    idle(C);
    // 5: break of 20 bit times gives one frame_err, then CANCEL
    expect_frame(8'h00, 1'b1, cyc);
    rx = 1'b0;
    repeat (20 * C) @(posedge clk);
    #1;
    idle(2 * C);
    send_frame(8'h40, 1'b0);
    idle(C);
    // 6: reset during data bit 3 of 0x25, released while rx is low
    drive_bit(1'b0);
    drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    rx = 1'b0;
    repeat (C / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_data = '0; m_gsel = '0; m_score = '0;
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("midreset");
    rst = 1'b0;
    repeat (3 * C) @(posedge clk);
    #1;
    check_all_zero("rearm");
    idle(2 * C);
    send_frame(8'h25, 1'b0);
    idle(C);

    // Random frames, roughly one in five with a parity error, random gaps (0 = back-to-back).
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      send_frame(b, $urandom_range(0, 4) == 0);
      idle($urandom_range(0, C));
    end

    waited = 0;
    while (q.size() != 0 && waited < 400) begin
      @(posedge clk);
      waited++;
    end
    chk("drain_pending", q.size(), 0);
    idle(2 * C);
    chk("final_rx_data", rx_data, m_data);
    chk("final_game_sel", game_sel, m_gsel);
    chk("final_remote_score", remote_score, m_score);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
